// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared widths and types for the sequential divider
package div_pkg;

  localparam int DIV_W = 32;

  typedef logic [2*DIV_W-1:0] rem_t;

endpackage

// File: rtl/divider_remainder_reg.sv
// rtl/divider_remainder_reg.sv - combined remainder/quotient register of the shift-subtract divider
module divider_remainder_reg
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2*WIDTH-1:0] Remainder_input,
  input  logic               wrctrl,
  input  logic               ozctrl,
  input  logic               ready,
  input  logic               ready_wait,
  output logic [WIDTH-1:0]   Remainder_output,
  output logic [WIDTH-1:0]   Quotient_output
);

  // Upper half is the running remainder, lower half collects quotient bits.
  logic [2*WIDTH-1:0] rem_q, rem_d;
  // Set once the final right shift of the remainder half has been applied,
  // so a ready_wait held for several cycles shifts only once per load.
  logic               rshift_done_q, rshift_done_d;

  // Next-state selection: load > one-shot right shift > hold > left shift.
  always_comb begin
    rem_d         = rem_q;
    rshift_done_d = rshift_done_q;
    if (wrctrl) begin
      rem_d         = Remainder_input;
      rshift_done_d = 1'b0;
    end else if (ready_wait && !rshift_done_q) begin
      rem_d[2*WIDTH-1:WIDTH] = {1'b0, rem_q[2*WIDTH-1:WIDTH+1]};
      rshift_done_d          = 1'b1;
    end else if (!ready && !ready_wait) begin
      // Default iteration step: shift left, quotient bit enters at the LSB.
      rem_d = {rem_q[2*WIDTH-2:0], ozctrl};
    end
  end

  // State register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q         <= '0;
      rshift_done_q <= 1'b0;
    end else begin
      rem_q         <= rem_d;
      rshift_done_q <= rshift_done_d;
    end
  end

  // Results are visible only while ready is high; zero otherwise.
  assign Remainder_output = rem_q[2*WIDTH-1:WIDTH] & {WIDTH{ready}};
  assign Quotient_output  = rem_q[WIDTH-1:0]       & {WIDTH{ready}};

endmodule

// File: tb/tb_divider_remainder_reg.sv
// tb/tb_divider_remainder_reg.sv - self-checking bench for divider_remainder_reg
module tb_divider_remainder_reg;
  import div_pkg::*;

  logic        clk;
  logic        rst;
  rem_t        Remainder_input;
  logic        wrctrl;
  logic        ozctrl;
  logic        ready;
  logic        ready_wait;
  logic [31:0] Remainder_output;
  logic [31:0] Quotient_output;

  int passed;
  int total;

  divider_remainder_reg #(.WIDTH(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .Remainder_input  (Remainder_input),
    .wrctrl           (wrctrl),
    .ozctrl           (ozctrl),
    .ready            (ready),
    .ready_wait       (ready_wait),
    .Remainder_output (Remainder_output),
    .Quotient_output  (Quotient_output)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] load;
    int          nshift;
    logic [7:0]  oz;
    int          nrw;
    logic [31:0] er;
    logic [31:0] eq;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] exp_r, input logic [31:0] exp_q);
    total++;
    if (Remainder_output === exp_r && Quotient_output === exp_q) begin
      passed++;
    end else begin
      $display("FAIL %s: got rem=%h quo=%h expected rem=%h quo=%h",
               name, Remainder_output, Quotient_output, exp_r, exp_q);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wrctrl     = 1'b0;
    ozctrl     = 1'b0;
    ready      = 1'b0;
    ready_wait = 1'b0;
  endtask

  // Reference state for the random phase
  logic [63:0] m;
  bit          m_done;

  initial begin
    passed = 0;
    total  = 0;

    tbl[0] = '{64'd16,                  0, 8'h00, 0, 32'd0,          32'd16};
    tbl[1] = '{64'd12,                  1, 8'h01, 0, 32'd0,          32'd25};
    tbl[2] = '{64'd12,                  2, 8'h00, 0, 32'd0,          32'd48};
    tbl[3] = '{64'h0000_0000_8000_0000, 1, 8'h00, 0, 32'd1,          32'd0};
    tbl[4] = '{64'h0000_0006_0000_0005, 0, 8'h00, 3, 32'd3,          32'd5};
    tbl[5] = '{64'h0000_000A_0000_0001, 0, 8'h00, 1, 32'd5,          32'd1};
    tbl[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 1, 8'h00, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    tbl[7] = '{64'h0000_0001_8000_0001, 2, 8'h03, 1, 32'd3,          32'd7};
    tbl[8] = '{64'h8000_0000_0000_0000, 1, 8'h00, 0, 32'd0,          32'd0};
    tbl[9] = '{64'h0000_0007_0000_0000, 0, 8'h00, 2, 32'd3,          32'd0};

    // Reset state
    Remainder_input = '0;
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    ready = 1'b1;
    #1;
    check("reset_state", 32'd0, 32'd0);
    rst = 1'b0;
    #1;
    check("after_reset_release", 32'd0, 32'd0);

    // Load and hold with ready
    ready           = 1'b0;
    wrctrl          = 1'b1;
    Remainder_input = 64'd16;
    tick();
    wrctrl = 1'b0;
    ready  = 1'b1;
    #1;
    check("load16_ready", 32'd0, 32'd16);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("load16_hold", 32'd0, 32'd16);
    end
    ready = 1'b0;
    #1;
    check("ready_low_gates", 32'd0, 32'd0);

    // Async reset between edges clears without a clock
    ready = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    check("async_reset", 32'd0, 32'd0);
    rst = 1'b0;
    idle_inputs();
    #1;

    // Table-driven vectors
    for (int k = 0; k < 10; k++) begin
      idle_inputs();
      wrctrl          = 1'b1;
      Remainder_input = tbl[k].load;
      tick();
      wrctrl = 1'b0;
      for (int i = 0; i < tbl[k].nshift; i++) begin
        ozctrl = tbl[k].oz[i];
        tick();
      end
      ozctrl     = 1'b0;
      ready_wait = 1'b1;
      for (int i = 0; i < tbl[k].nrw; i++) tick();
      ready_wait = 1'b0;
      ready      = 1'b1;
      #1;
      check($sformatf("table_%0d", k), tbl[k].er, tbl[k].eq);
    end

    // Priority: load wins over ready and ready_wait, then shift once, then hold
    idle_inputs();
    wrctrl          = 1'b1;
    ready           = 1'b1;
    ready_wait      = 1'b1;
    Remainder_input = 64'd4294967296;
    tick();
    check("prio_load", 32'd1, 32'd0);
    wrctrl = 1'b0;
    tick();
    check("prio_rshift", 32'd0, 32'd0);
    tick();
    check("prio_hold", 32'd0, 32'd0);

    // One-shot right shift persists while ready holds in between
    idle_inputs();
    wrctrl          = 1'b1;
    Remainder_input = 64'h0000_0010_0000_0003;
    tick();
    wrctrl     = 1'b0;
    ready_wait = 1'b1;
    tick();
    ready_wait = 1'b0;
    ready      = 1'b1;
    tick();
    ready_wait = 1'b1;
    tick();
    tick();
    check("rshift_once", 32'd8, 32'd3);

    // Random stimulus against arithmetic reference model
    idle_inputs();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    m      = 64'd0;
    m_done = 1'b0;
    for (int n = 0; n < 400; n++) begin
      wrctrl          = ($urandom_range(0, 7) == 0) || (n == 0);
      ready_wait      = ($urandom_range(0, 3) == 0);
      ready           = ($urandom_range(0, 2) == 0);
      ozctrl          = $urandom_range(0, 1);
      Remainder_input = {$urandom(), $urandom()};
      #1;
      check("rand_comb", ready ? m[63:32] : 32'd0, ready ? m[31:0] : 32'd0);
      tick();
      if (wrctrl) begin
        m      = Remainder_input;
        m_done = 1'b0;
      end else if (ready_wait && !m_done) begin
        m      = {m[63:32] / 32'd2, m[31:0]};
        m_done = 1'b1;
      end else if (!ready && !ready_wait) begin
        m = m * 64'd2 + {63'd0, ozctrl};
      end
      check("rand_edge", ready ? m[63:32] : 32'd0, ready ? m[31:0] : 32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
